// File: rtl/pulse_bram_fp32.sv
// rtl/pulse_bram_fp32.sv - pulse waveform word RAM with combinational fp32 adder
// Single-port RAM (1-cycle registered read) beside an FTZ, round-to-nearest-even binary32 adder.
module pulse_bram_fp32 #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic        clka,
  input  logic        rst,
  input  logic        ena,
  input  logic        wea,
  input  logic [31:0] addra,
  input  logic [31:0] dina,
  output logic [31:0] douta,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   douta_q;
  logic [AW-1:0] word;
  logic          unused_bits;

  assign word        = addra[AW+1:2];
  assign unused_bits = ^{addra[31:AW+2], addra[1:0]};
  assign douta       = douta_q;

  always_ff @(posedge clka) begin
    if (ena && wea) mem_q[word] <= dina;
  end

  // Reset only touches the output register; the stored waveform survives it.
  always_ff @(posedge clka or posedge rst) begin
    if (rst)              douta_q <= 32'h0;
    else if (ena && !wea) douta_q <= mem_q[word];
  end

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++) if (v[i]) lzc27 = 5'(26 - i);
  endfunction

  logic              z_a, z_b, i_a, i_b, n_a, n_b;
  logic              a_big, s_l, s_s, stk, up;
  logic [7:0]        e_l, e_s, diff;
  logic [23:0]       m_l, m_s;
  logic [26:0]       ext_s, al, mask, norm;
  logic [27:0]       sum;
  logic [4:0]        lz;
  logic signed [9:0] exp_n, exp_r;
  logic [24:0]       m_rnd;
  logic [22:0]       frac;

  assign z_a = (a[30:23] == 8'h00);
  assign z_b = (b[30:23] == 8'h00);
  assign i_a = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
  assign i_b = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
  assign n_a = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
  assign n_b = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);

  // Three extra bits below the significand act as guard, round and sticky.
  always_comb begin
    a_big = (a[30:0] >= b[30:0]);
    s_l   = a_big ? a[31] : b[31];
    s_s   = a_big ? b[31] : a[31];
    e_l   = a_big ? a[30:23] : b[30:23];
    e_s   = a_big ? b[30:23] : a[30:23];
    m_l   = {1'b1, a_big ? a[22:0] : b[22:0]};
    m_s   = {1'b1, a_big ? b[22:0] : a[22:0]};
    diff  = e_l - e_s;
    ext_s = {m_s, 3'b000};
    mask  = (27'd1 << diff) - 27'd1;
    if (diff >= 8'd27) begin
      al  = 27'h0;
      stk = 1'b1;
    end else begin
      al  = ext_s >> diff;
      stk = |(ext_s & mask);
    end
    al[0] = al[0] | stk;
    if (s_l ^ s_s) sum = {1'b0, m_l, 3'b000} - {1'b0, al};
    else           sum = {1'b0, m_l, 3'b000} + {1'b0, al};
    lz = lzc27(sum[26:0]);
    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      exp_n = $signed({2'b00, e_l}) + 10'sd1;
    end else begin
      norm  = sum[26:0] << lz;
      exp_n = $signed({2'b00, e_l}) - $signed({5'b00000, lz});
    end
    up    = norm[2] & (norm[1] | norm[0] | norm[3]);
    m_rnd = {1'b0, norm[26:3]} + {24'h0, up};
    exp_r = m_rnd[24] ? exp_n + 10'sd1 : exp_n;
    frac  = m_rnd[24] ? m_rnd[23:1] : m_rnd[22:0];
  end

  always_comb begin
    result = 32'h0;
    if (n_a || n_b || (i_a && i_b && (a[31] != b[31]))) result = 32'h7FC00000;
    else if (i_a)                                      result = a;
    else if (i_b)                                      result = b;
    else if (z_a && z_b)                               result = {a[31] & b[31], 31'h0};
    else if (z_a)                                      result = b;
    else if (z_b)                                      result = a;
    else if (sum == 28'h0)                             result = 32'h0;
    else if (exp_r >= 10'sd255)                        result = {s_l, 8'hFF, 23'h0};
    else if (exp_r <= 10'sd0)                          result = 32'h0;
    else                                               result = {s_l, exp_r[7:0], frac};
  end

endmodule

// File: tb/tb_pulse_bram_fp32.sv
// tb/tb_pulse_bram_fp32.sv - scoreboard bench for pulse_bram_fp32
// RAM and adder expectations come from an array model and real-valued fp arithmetic.
module tb_pulse_bram_fp32;

  logic        clka = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b0, wea = 1'b0;
  logic [31:0] addra = 32'h0, dina = 32'h0, a = 32'h0, b = 32'h0;
  logic [31:0] douta, result;

  int          total = 0, bad = 0;
  logic [31:0] mdl [4096];
  logic [31:0] rd_q[$], add_q[$];
  logic [31:0] last_rd = 32'h0;
  logic        add_vld = 1'b0;
  logic        rd_seen;
  logic [31:0] samp [50];

  always #5 clka = ~clka;

  pulse_bram_fp32 #(.DEPTH(4096), .AW(12)) dut (
    .clka(clka), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta), .a(a), .b(b), .result(result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    d = {x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real v);
    logic [63:0] d;
    logic [52:0] m;
    logic [24:0] t;
    int          e;
    d = $realtobits(v);
    e = int'(d[62:52]) - 896;
    m = {1'b1, d[51:0]};
    t = {1'b0, m[52:29]};
    if (m[28:0] > 29'h10000000 || (m[28:0] == 29'h10000000 && t[0])) t = t + 25'd1;
    if (t[24]) begin
      t = t >> 1;
      e++;
    end
    if (e >= 255) return {d[63], 8'hFF, 23'h0};
    if (e <= 0) return 32'h0;
    return {d[63], 8'(e), t[22:0]};
  endfunction

  function automatic logic [31:0] fp_model(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] p, q;
    real         r;
    p = (x[30:23] == 8'h0) ? {x[31], 31'h0} : x;
    q = (y[30:23] == 8'h0) ? {y[31], 31'h0} : y;
    if ((p[30:23] == 8'hFF && p[22:0] != 0) || (q[30:23] == 8'hFF && q[22:0] != 0)) return 32'h7FC00000;
    if (p[30:0] == 31'h7F800000 && q[30:0] == 31'h7F800000 && p[31] != q[31]) return 32'h7FC00000;
    if (p[30:0] == 31'h7F800000) return p;
    if (q[30:0] == 31'h7F800000) return q;
    if (p[30:0] == 0 && q[30:0] == 0) return {p[31] & q[31], 31'h0};
    if (p[30:0] == 0) return q;
    if (q[30:0] == 0) return p;
    r = f2r(p) + f2r(q);
    if (r == 0.0) return 32'h0;
    return r2f(r);
  endfunction

  // RAM monitor: a read edge must deliver the queued word, any other edge must hold douta.
  always @(posedge clka) begin
    if (!rst) begin
      rd_seen = ena && !wea;
      #1;
      if (rd_seen) begin
        if (rd_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL ram_read: douta=%08h with no expected word queued", douta);
        end else begin
          last_rd = rd_q.pop_front();
          check("ram_read", douta, last_rd);
        end
      end else begin
        check("ram_hold", douta, last_rd);
      end
    end
  end

  always @(posedge rst) last_rd = 32'h0;

  always @(posedge clka) begin
    if (add_vld) begin
      #1;
      if (add_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL fp_add: result=%08h with no expected value queued", result);
      end else begin
        check($sformatf("fp_add %08h+%08h", a, b), result, add_q.pop_front());
      end
    end
  end

  task automatic ram_op(input logic en, input logic we, input logic [31:0] ad, input logic [31:0] d);
    @(negedge clka);
    ena = en; wea = we; addra = ad; dina = d;
    if (en && we) mdl[ad[13:2]] = d;
    else if (en)  rd_q.push_back(mdl[ad[13:2]]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clka);
      ena = 1'b0; wea = 1'b0;
    end
  endtask

  task automatic add_op(input logic [31:0] x, input logic [31:0] y, input logic [31:0] exp);
    @(negedge clka);
    a = x; b = y; add_vld = 1'b1;
    add_q.push_back(exp);
  endtask

  initial begin
    #1000000;
    total++;
    bad++;
    $display("FAIL watchdog: simulation exceeded time budget");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [31:0] x, y, ad;
    int          w;
    for (int i = 0; i < 4096; i++) mdl[i] = 32'h0;
    #1 rst = 1'b1;
    #2 check("reset_douta", douta, 32'h0);
    repeat (2) @(posedge clka);
    @(negedge clka) rst = 1'b0;

    ram_op(1, 1, 32'h10, 32'h3F59AD43);
    ram_op(1, 0, 32'h10, 32'h0);
    ram_op(1, 0, 32'h14, 32'h0);
    ram_op(0, 1, 32'h20, 32'hDEADBEEF);
    ram_op(1, 0, 32'h20, 32'h0);
    ram_op(1, 1, 32'h4000, 32'h12345678);
    ram_op(1, 0, 32'h0, 32'h0);
    idle(1);

    ram_op(1, 0, 32'h10, 32'h0);
    idle(1);
    @(negedge clka);
    #1 rst = 1'b1;
    #1 check("rst_pulse_douta", douta, 32'h0);
    #2 rst = 1'b0;
    ram_op(1, 0, 32'h10, 32'h0);
    idle(2);

    add_op(32'h3DA339C1, 32'h00000000, 32'h3DA339C1);
    add_op(32'h3F800000, 32'h3F800000, 32'h40000000);
    add_op(32'h3F800000, 32'hBF800000, 32'h00000000);
    add_op(32'h3F800000, 32'h33800000, 32'h3F800000);
    add_op(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
    add_op(32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000);
    add_op(32'h7F800000, 32'hFF800000, 32'h7FC00000);
    add_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000);
    add_op(32'h00400000, 32'h00400000, 32'h00000000);
    add_op(32'h80000000, 32'h80000000, 32'h80000000);
    add_op(32'hFF800000, 32'h42F60000, 32'hFF800000);
    @(negedge clka) add_vld = 1'b0;

    // Accumulate two passes of samples into words 256..305 through the adder.
    for (int i = 0; i < 50; i++)
      samp[i] = {1'b0, 8'(110 + $urandom_range(0, 30)), 23'($urandom())};
    samp[0] = 32'h3F800000;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 50; i++) begin
        w = 256 + i;
        ram_op(1, 0, 32'(w << 2), 32'h0);
        @(negedge clka);
        ena = 1'b0; a = douta; b = samp[i]; add_vld = 1'b1;
        add_q.push_back(fp_model(mdl[w], samp[i]));
        @(negedge clka);
        add_vld = 1'b0;
        ena = 1'b1; wea = 1'b1; addra = 32'(w << 2); dina = result;
        mdl[w] = fp_model(mdl[w], samp[i]);
      end
    end
    for (int i = 0; i < 50; i++) ram_op(1, 0, 32'((256 + i) << 2), 32'h0);
    idle(2);
    check("accum_word0", mdl[256], 32'h40000000);

    for (int n = 0; n < 300; n++) begin
      w  = 64 + $urandom_range(0, 63);
      ad = ($urandom() & ~32'h00003FFC) | 32'(w << 2);
      case ($urandom_range(0, 3))
        0:       ram_op(0, 1'($urandom()), ad, $urandom());
        1:       ram_op(1, 1, ad, $urandom());
        default: ram_op(1, 0, ad, $urandom());
      endcase
    end
    idle(2);

    for (int n = 0; n < 300; n++) begin
      x = $urandom();
      case ($urandom_range(0, 3))
        0: y = $urandom();
        1: y = {1'($urandom()), x[30:23] + 8'($urandom_range(0, 6)) - 8'd3, 23'($urandom())};
        2: y = {~x[31], x[30:23], x[22:0] ^ 23'($urandom_range(0, 7))};
        default: begin
          case ($urandom_range(0, 5))
            0: y = 32'h00000000;
            1: y = 32'h80000000;
            2: y = 32'h7F800000;
            3: y = 32'hFF800000;
            4: y = 32'h7FC00001;
            default: y = 32'h00400000;
          endcase
        end
      endcase
      add_op(x, y, fp_model(x, y));
    end
    @(negedge clka) add_vld = 1'b0;
    idle(3);

    check("rd_q_drained", 32'(rd_q.size()), 32'h0);
    check("add_q_drained", 32'(add_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
